// File: rtl/mem_burst_sequencer.sv
// mem_burst_sequencer
// Turns one arbiter request into single-word bus beats.
// A read issues rlen+1 beats at consecutive word addresses, wrapping modulo 2^30.
// A write always issues exactly one beat.
// Every bus-side output is decoded from registered state, so it holds steady while a beat stalls.
module mem_burst_sequencer #(
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  // arbiter side
  input  logic            mem_request,
  input  logic [29:0]     mem_addr,
  input  logic [4:0]      mem_rlen,
  input  logic            mem_rnw,
  input  logic            mem_rmw,
  input  logic [3:0]      mem_wbe,
  input  logic [31:0]     mem_wdata,
  input  logic [ID_W-1:0] mem_id,
  output logic            mem_ack,
  output logic            mem_rvalid,
  output logic [31:0]     mem_rdata,
  output logic [ID_W-1:0] mem_rid,
  output logic            mem_write_outstanding,
  output logic            mem_inv,
  output logic [29:0]     mem_inv_addr,
  // bus side
  output logic            bus_req,
  output logic [29:0]     bus_addr,
  output logic            bus_we,
  output logic [3:0]      bus_be,
  output logic [31:0]     bus_wdata,
  output logic            bus_lock,
  input  logic            bus_ack,
  input  logic [31:0]     bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        beat_q, beat_d;
  logic [29:0]       addr_q, addr_d;
  logic [4:0]        rlen_q, rlen_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rmw_q, rmw_d;
  logic [3:0]        wbe_q, wbe_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ID_W-1:0]   rid_q, rid_d;

  // Next-state logic: accept in IDLE, count read beats on bus_ack, finish a write on its single ack
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    rlen_d   = rlen_q;
    id_d     = id_q;
    rmw_d    = rmw_q;
    wbe_d    = wbe_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    case (state_q)
      S_IDLE: begin
        if (mem_request) begin
          addr_d  = mem_addr;
          rlen_d  = mem_rlen;
          id_d    = mem_id;
          rmw_d   = mem_rmw;
          wbe_d   = mem_wbe;
          wdata_d = mem_wdata;
          beat_d  = 5'd0;
          state_d = mem_rnw ? S_READ : S_WRITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        if (bus_ack) begin
          rvalid_d = 1'b1;
          rdata_d  = bus_rdata;
          rid_d    = id_q;
          if (beat_q == rlen_q) begin
            beat_d  = 5'd0;
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 5'd1;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (bus_ack) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WRITE;
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 5'd0;
      end
    endcase
  end

  // State and captured-request registers; reset aborts any burst at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= 5'd0;
      addr_q   <= 30'd0;
      rlen_q   <= 5'd0;
      id_q     <= '0;
      rmw_q    <= 1'b0;
      wbe_q    <= 4'd0;
      wdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      rlen_q   <= rlen_d;
      id_q     <= id_d;
      rmw_q    <= rmw_d;
      wbe_q    <= wbe_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
    end
  end

  // Accept is combinational so a waiting request is taken in the same IDLE cycle
  assign mem_ack = mem_request & (state_q == S_IDLE) & ~rst;

  assign mem_rvalid            = rvalid_q;
  assign mem_rdata             = rdata_q;
  assign mem_rid               = rid_q;
  assign mem_write_outstanding = (state_q == S_WRITE);
  assign mem_inv               = 1'b0;
  assign mem_inv_addr          = 30'd0;

  assign bus_req   = (state_q != S_IDLE);
  assign bus_addr  = addr_q + {25'd0, beat_q};
  assign bus_we    = (state_q == S_WRITE);
  assign bus_be    = (state_q == S_WRITE) ? wbe_q : 4'hF;
  assign bus_wdata = wdata_q;
  assign bus_lock  = (state_q != S_IDLE) & rmw_q;

endmodule

// File: doc/mem_burst_sequencer.md
MEM_BURST_SEQUENCER -- requirements
Module: mem_burst_sequencer

Interface
REQ-001 Parameter ID_W, default 2, SHALL set the request/response ID width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 mem_request  input  1  SHALL indicate a pending request from the arbiter.
REQ-005 mem_addr  input  30  SHALL carry the word address, bits [31:2].
REQ-006 mem_rlen  input  5  SHALL carry read burst length minus one, in words.
REQ-007 mem_rnw  input  1  SHALL indicate read (1) or write (0).
REQ-008 mem_rmw  input  1  SHALL mark a locked read-modify-write access.
REQ-009 mem_wbe  input  4  SHALL carry write byte enables.
REQ-010 mem_wdata  input  32  SHALL carry write data.
REQ-011 mem_id  input  ID_W  SHALL carry the requester ID.
REQ-012 mem_ack  output  1  SHALL accept the presented request.
REQ-013 mem_rvalid  output  1  SHALL mark one valid read-data word.
REQ-014 mem_rdata  output  32  SHALL carry read data.
REQ-015 mem_rid  output  ID_W  SHALL carry the ID of the returning read.
REQ-016 mem_write_outstanding  output  1  SHALL flag an accepted but incomplete write.
REQ-017 mem_inv  output  1 and mem_inv_addr  output  30  SHALL be tied to 0; no coherence source exists.
REQ-018 bus_req  output  1  SHALL request one single-word bus beat.
REQ-019 bus_addr  output  30 / bus_we  output  1 / bus_be  output  4 / bus_wdata  output  32  SHALL describe the beat.
REQ-020 bus_lock  output  1  SHALL hold the bus for an rmw transaction.
REQ-021 bus_ack  input  1 / bus_rdata  input  32  SHALL complete a beat; rdata valid when bus_ack=1.

Function
REQ-022 States SHALL be IDLE, READ and WRITE.
REQ-023 mem_ack SHALL be combinational: mem_request & state==IDLE.
REQ-024 On accept, the block SHALL capture addr, rlen, id, rmw, wbe, wdata; next state READ if rnw=1, else WRITE.
REQ-025 READ SHALL issue rlen+1 beats; bus_req high every cycle in READ; bus_addr = captured addr + beat count, modulo 2^30 (wrap from 0x3FFFFFFF to 0).
REQ-026 Beat counter (5 bits) SHALL advance only on bus_ack; READ->IDLE on bus_ack when counter==captured rlen.
REQ-027 WRITE SHALL issue exactly one beat regardless of rlen, with bus_we=1, captured wbe/wdata; WRITE->IDLE on bus_ack.
REQ-028 bus_we=0 and bus_be=4'hF in READ; bus outputs SHALL stay stable while bus_req=1 and bus_ack=0.
REQ-029 mem_rvalid SHALL assert exactly one cycle after each READ bus_ack, with mem_rdata=registered bus_rdata and mem_rid=captured id; latency bus_ack->rvalid = 1 cycle.
REQ-030 mem_write_outstanding SHALL be high from the cycle after write accept through the cycle of the write bus_ack, low otherwise.
REQ-031 bus_lock SHALL equal captured rmw while state != IDLE, else 0.
REQ-032 Earliest new accept SHALL be the cycle after the final bus_ack (IDLE re-entered); no back-to-back overlap.
REQ-033 bus_ack while bus_req=0 SHALL be ignored.
REQ-034 Memory requests with mem_request=0 SHALL never change state, regardless of other inputs.

Reset
REQ-035 On rst: state=IDLE, beat counter=0, bus_req=0, bus_lock=0, mem_rvalid=0, mem_write_outstanding=0, captured fields=0; mem_ack=0 while rst asserted.
REQ-036 Reset mid-burst SHALL abort the transaction immediately with no further rvalid; the first post-reset request SHALL be accepted normally.

Verification
REQ-037 Read addr=0x100, rlen=3, id=2, bus_ack every cycle -> bus_addr 0x100..0x103, four rvalid pulses with rid=2, one cycle after each ack.
REQ-038 Write addr=0x40, wbe=4'b0011, wdata=0xDEADBEEF, rlen=7, bus_ack after 3 wait cycles -> one beat only, write_outstanding high 4 cycles then low, no rvalid.
REQ-039 Read addr=0x3FFFFFFE, rlen=2 -> bus_addr 0x3FFFFFFE, 0x3FFFFFFF, 0x0.
REQ-040 rmw read, rlen=0 -> bus_lock=1 from cycle after accept until final bus_ack, 0 after.
REQ-041 rst asserted after 2 of 8 read beats -> bus_req and rvalid drop asynchronously; next read addr=0x10 rlen=0 completes with one rvalid.
REQ-042 mem_request held high across completion -> mem_ack low during READ/WRITE, high again in the IDLE cycle after the last bus_ack.
